iq_dispatch_arbiter: RTL and testbench
======================================

# iq_dispatch_arbiter

Sits between the renamer and the issue queues and steers each renamed instruction to exactly one issue queue. The decoder marks which queues are eligible; among eligible queues that are ready, the block picks one round-robin. It holds the instruction in a one-entry stage and snoops FU wakeup broadcasts so an operand readiness update is never lost while the instruction waits or on the cycle it is inserted. Throughput is one instruction per cycle; latency is one cycle.

## Interface
- INST_ID_BITS, 6, instruction id width
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, operand slots per instruction
- IQ_COUNT, 4, number of downstream issue queues (≥2)
- FU_COUNT, 4, number of wakeup broadcast sources

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard held and incoming instruction
- in_valid  in  1  renamer offers an instruction
- in_ready  out  1  block can accept this cycle
- in_inst_id  in  INST_ID_BITS  instruction id
- in_raw_instr  in  32  raw encoding
- in_pc  in  64  instruction PC
- in_iq_mask  in  IQ_COUNT  bit q set = queue q eligible
- in_prn_input_valid / in_prn_input_ready  in  1 each ×MAX_OPERANDS  operand used / operand already ready
- in_prn_input  in  PRN_BITS ×MAX_OPERANDS  source PRNs
- in_prn_output_valid  in  1 ×MAX_OPERANDS  destination used
- in_prn_output  in  PRN_BITS ×MAX_OPERANDS  destination PRNs
- set_prn_ready  in  1 [FU_COUNT][MAX_OPERANDS]  wakeup strobes
- set_prn  in  PRN_BITS [FU_COUNT][MAX_OPERANDS]  wakeup PRNs
- iq_queue_ready  in  IQ_COUNT  per-queue free-slot indication
- iq_inst_valid  out  IQ_COUNT  one-hot insert strobe
- iq_inst_id, iq_raw_instr, iq_instr_pc, iq_prn_input_valid, iq_prn_input_ready, iq_prn_input, iq_prn_output_valid, iq_prn_output  out  same widths as inputs  shared payload bus to all queues
- route_err  out  1  one-cycle pulse: held instruction had empty mask
- stall_cycles  out  32  stall counter (see Configuration)
- dispatch_count  out  32  dispatched-instruction counter (see Configuration)

## Operation
- State:
  - held_valid, the held payload, and held_ready[MAX_OPERANDS].
  - rr_ptr of clog2(IQ_COUNT) bits.
- Wake match for a PRN p: any set_prn_ready[k][m] with set_prn[k][m]==p, over all k and m (any slot, not only the same operand index).
- Grant selection:
  - cand = held_mask & iq_queue_ready.
  - g = first set bit of cand, searching from rr_ptr upward with wrap.
  - fire = held_valid && cand≠0 && !flush.
- Outputs:
  - iq_inst_valid[g] = fire; all other bits are 0.
  - iq_prn_input_ready[i] = held_ready[i] | match(held prn[i]). This covers the issue queue not applying wakeups on its insert cycle.
- in_ready = !flush && (!held_valid || fire || held_mask==0).
- On accept (in_valid && in_ready):
  - Load the payload.
  - held_ready[i] = in_prn_input_ready[i] | match(in_prn_input[i]).
- While holding without fire: held_ready[i] |= match(held prn[i]) every cycle.
- On fire: rr_ptr ← (g+1) mod IQ_COUNT. If there is no new accept, held_valid ← 0.
- Empty mask: the held instruction is dropped at the next edge. route_err is high combinationally during its held cycle. No queue is strobed and rr_ptr is unchanged.
- Flush has priority over everything:
  - held_valid ← 0 at the edge.
  - in_ready = 0 and iq_inst_valid = 0 that cycle.
  - rr_ptr is preserved.

## Timing
- Reset values:
  - held_valid=0, rr_ptr=0.
  - All iq_* outputs 0, route_err=0, counters 0.
  - in_ready=1 in the first cycle after reset.
- Latency: an accept at edge N produces the insert strobe in cycle N+1 at the earliest.
- Output strobes are combinational from held state and iq_queue_ready. No path exists from in_valid to iq_inst_valid.
- Back-to-back: simultaneous fire and accept sustain 1 instr/cycle.
- Mid-operation reset clears held state at the edge, with the same priority as flush.
- rr_ptr wraps from IQ_COUNT-1 to 0.

## Configuration
- DISPATCH_STATS_EN defined:
  - stall_cycles increments on every cycle with held_valid && !fire && !flush && held_mask≠0.
  - dispatch_count increments on each fire.
  - Both are 32-bit, saturate at 2^32-1, and clear on rst.
- DISPATCH_STATS_EN undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Mask 4'b0011, all queues ready, rr_ptr=0: two back-to-back instructions go to queue 0 then queue 1. rr_ptr ends at 2 and in_ready stays 1.
- Mask 4'b0100 with iq_queue_ready[2]=0 for 3 cycles: the instruction stays held and in_ready=0. It fires in cycle 4, and with DISPATCH_STATS_EN stall_cycles=3.
- Held instruction with prn[1]=9 not ready; set_prn[2][0]=9 strobed while stalled: iq_prn_input_ready[1]=1 on the fire cycle.
- Wakeup of prn 5 in the same cycle as the fire: iq_prn_input_ready for the operand on prn 5 is 1 combinationally.
- Mask 4'b0000: route_err pulses for 1 cycle, no iq_inst_valid, and the next instruction is accepted the same cycle.
- flush while held and in_valid=1: nothing is dispatched and in_ready=0. held_valid=0 next cycle and rr_ptr is unchanged.

Source files
------------

// File: rtl/iq_dispatch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iq_dispatch_arbiter: one-entry stage steering renamed instructions to a   |
// | round-robin-selected ready issue queue while snooping FU wakeups.         |
// | Optional statistics counters: define DISPATCH_STATS_EN.                   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module iq_dispatch_arbiter #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int IQ_COUNT     = 4,
    parameter int FU_COUNT     = 4
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               flush,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [INST_ID_BITS-1:0]                            in_inst_id,
    input  logic [31:0]                                        in_raw_instr,
    input  logic [63:0]                                        in_pc,
    input  logic [IQ_COUNT-1:0]                                in_iq_mask,
    input  logic [MAX_OPERANDS-1:0]                            in_prn_input_valid,
    input  logic [MAX_OPERANDS-1:0]                            in_prn_input_ready,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              in_prn_input,
    input  logic [MAX_OPERANDS-1:0]                            in_prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              in_prn_output,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]              set_prn_ready,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    input  logic [IQ_COUNT-1:0]                                iq_queue_ready,
    output logic [IQ_COUNT-1:0]                                iq_inst_valid,
    output logic [INST_ID_BITS-1:0]                            iq_inst_id,
    output logic [31:0]                                        iq_raw_instr,
    output logic [63:0]                                        iq_instr_pc,
    output logic [MAX_OPERANDS-1:0]                            iq_prn_input_valid,
    output logic [MAX_OPERANDS-1:0]                            iq_prn_input_ready,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              iq_prn_input,
    output logic [MAX_OPERANDS-1:0]                            iq_prn_output_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              iq_prn_output,
    output logic                                               route_err,
    output logic [31:0]                                        stall_cycles,
    output logic [31:0]                                        dispatch_count
);

    localparam int PTR_W = $clog2(IQ_COUNT);

    logic                                  r_held_valid;
    logic [INST_ID_BITS-1:0]               r_inst_id;
    logic [31:0]                           r_raw_instr;
    logic [63:0]                           r_pc;
    logic [IQ_COUNT-1:0]                   r_mask;
    logic [MAX_OPERANDS-1:0]               r_prn_input_valid;
    logic [MAX_OPERANDS-1:0]               r_held_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_prn_input;
    logic [MAX_OPERANDS-1:0]               r_prn_output_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_prn_output;
    logic [PTR_W-1:0]                      r_rr_ptr;

    logic [IQ_COUNT-1:0]                   w_cand;
    logic                                  w_grant_found;
    logic [PTR_W-1:0]                      w_grant_idx;
    logic [PTR_W-1:0]                      w_rr_next;
    logic                                  w_fire;
    logic                                  w_accept;
    logic                                  w_stall;
    logic [MAX_OPERANDS-1:0]               w_match_held;
    logic [MAX_OPERANDS-1:0]               w_match_in;

    // Any wakeup slot may carry any PRN, so every operand compares against all of them.
    always_comb begin
        w_match_held = '0;
        w_match_in   = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            for (int k = 0; k < FU_COUNT; k++) begin
                for (int m = 0; m < MAX_OPERANDS; m++) begin
                    if (set_prn_ready[k][m]) begin
                        if (set_prn[k][m] == r_prn_input[i]) w_match_held[i] = 1'b1;
                        if (set_prn[k][m] == in_prn_input[i]) w_match_in[i]  = 1'b1;
                    end
                end
            end
        end
    end

    assign w_cand = r_mask & iq_queue_ready;

    always_comb begin
        logic [PTR_W:0] slot;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        slot          = '0;
        for (int off = 0; off < IQ_COUNT; off++) begin
            slot = {1'b0, r_rr_ptr} + (PTR_W+1)'(off);
            if (slot >= (PTR_W+1)'(IQ_COUNT)) slot = slot - (PTR_W+1)'(IQ_COUNT);
            if (!w_grant_found && w_cand[slot[PTR_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = slot[PTR_W-1:0];
            end
        end
    end

    assign w_rr_next = (w_grant_idx == PTR_W'(IQ_COUNT-1)) ? '0 : w_grant_idx + PTR_W'(1);
    assign w_fire    = r_held_valid && w_grant_found && !flush;
    assign in_ready  = !flush && (!r_held_valid || w_fire || (r_mask == '0));
    assign w_accept  = in_valid && in_ready;
    assign w_stall   = r_held_valid && !w_fire && !flush && (r_mask != '0);
    assign route_err = r_held_valid && (r_mask == '0);

    always_comb begin
        iq_inst_valid = '0;
        if (w_fire) iq_inst_valid[w_grant_idx] = 1'b1;
    end

    // Wakeups arriving on the insert cycle are folded in here because the queue ignores them then.
    assign iq_prn_input_ready  = r_held_ready | w_match_held;
    assign iq_inst_id          = r_inst_id;
    assign iq_raw_instr        = r_raw_instr;
    assign iq_instr_pc         = r_pc;
    assign iq_prn_input_valid  = r_prn_input_valid;
    assign iq_prn_input        = r_prn_input;
    assign iq_prn_output_valid = r_prn_output_valid;
    assign iq_prn_output       = r_prn_output;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held_valid       <= 1'b0;
            r_inst_id          <= '0;
            r_raw_instr        <= '0;
            r_pc               <= '0;
            r_mask             <= '0;
            r_prn_input_valid  <= '0;
            r_held_ready       <= '0;
            r_prn_input        <= '0;
            r_prn_output_valid <= '0;
            r_prn_output       <= '0;
            r_rr_ptr           <= '0;
        end else if (flush) begin
            r_held_valid <= 1'b0;
        end else begin
            if (w_fire) r_rr_ptr <= w_rr_next;
            if (w_accept) begin
                r_held_valid       <= 1'b1;
                r_inst_id          <= in_inst_id;
                r_raw_instr        <= in_raw_instr;
                r_pc               <= in_pc;
                r_mask             <= in_iq_mask;
                r_prn_input_valid  <= in_prn_input_valid;
                r_held_ready       <= in_prn_input_ready | w_match_in;
                r_prn_input        <= in_prn_input;
                r_prn_output_valid <= in_prn_output_valid;
                r_prn_output       <= in_prn_output;
            end else if (w_stall) begin
                r_held_ready <= r_held_ready | w_match_held;
            end else begin
                r_held_valid <= 1'b0;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_dispatch_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles   <= '0;
            r_dispatch_count <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1))   r_stall_cycles   <= r_stall_cycles + 32'd1;
            if (w_fire && (r_dispatch_count != '1))  r_dispatch_count <= r_dispatch_count + 32'd1;
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign dispatch_count = r_dispatch_count;
`else
    assign stall_cycles   = '0;
    assign dispatch_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_dispatch_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iq_dispatch_arbiter: directed scenarios plus randomized traffic        |
// | checked against a behavioural model of the dispatch stage.                |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_iq_dispatch_arbiter;

    localparam int IDB = 6;
    localparam int PB  = 6;
    localparam int MO  = 3;
    localparam int IQ  = 4;
    localparam int FU  = 4;

    logic                       clk = 1'b0;
    logic                       rst, flush, in_valid, in_ready;
    logic [IDB-1:0]             in_inst_id;
    logic [31:0]                in_raw_instr;
    logic [63:0]                in_pc;
    logic [IQ-1:0]              in_iq_mask;
    logic [MO-1:0]              in_prn_input_valid, in_prn_input_ready, in_prn_output_valid;
    logic [MO-1:0][PB-1:0]      in_prn_input, in_prn_output;
    logic [FU-1:0][MO-1:0]      set_prn_ready;
    logic [FU-1:0][MO-1:0][PB-1:0] set_prn;
    logic [IQ-1:0]              iq_queue_ready, iq_inst_valid;
    logic [IDB-1:0]             iq_inst_id;
    logic [31:0]                iq_raw_instr;
    logic [63:0]                iq_instr_pc;
    logic [MO-1:0]              iq_prn_input_valid, iq_prn_input_ready, iq_prn_output_valid;
    logic [MO-1:0][PB-1:0]      iq_prn_input, iq_prn_output;
    logic                       route_err;
    logic [31:0]                stall_cycles, dispatch_count;

    iq_dispatch_arbiter #(
        .INST_ID_BITS(IDB), .PRN_BITS(PB), .MAX_OPERANDS(MO), .IQ_COUNT(IQ), .FU_COUNT(FU)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr), .in_pc(in_pc),
        .in_iq_mask(in_iq_mask), .in_prn_input_valid(in_prn_input_valid),
        .in_prn_input_ready(in_prn_input_ready), .in_prn_input(in_prn_input),
        .in_prn_output_valid(in_prn_output_valid), .in_prn_output(in_prn_output),
        .set_prn_ready(set_prn_ready), .set_prn(set_prn), .iq_queue_ready(iq_queue_ready),
        .iq_inst_valid(iq_inst_valid), .iq_inst_id(iq_inst_id), .iq_raw_instr(iq_raw_instr),
        .iq_instr_pc(iq_instr_pc), .iq_prn_input_valid(iq_prn_input_valid),
        .iq_prn_input_ready(iq_prn_input_ready), .iq_prn_input(iq_prn_input),
        .iq_prn_output_valid(iq_prn_output_valid), .iq_prn_output(iq_prn_output),
        .route_err(route_err), .stall_cycles(stall_cycles), .dispatch_count(dispatch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the held entry.
    bit                    m_valid = 0;
    logic [IDB-1:0]        m_id;
    logic [31:0]           m_raw;
    logic [63:0]           m_pc;
    logic [IQ-1:0]         m_mask;
    logic [MO-1:0]         m_pv, m_pr, m_ov;
    logic [MO-1:0][PB-1:0] m_prn, m_op;
    int                    m_rr = 0;
    longint                m_stall = 0;
    longint                m_disp = 0;

    logic [IQ-1:0]         obs_iv;
    logic                  obs_inr, obs_route;
    logic [MO-1:0]         obs_pr;
    logic [31:0]           obs_stall;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit wake(input logic [PB-1:0] p);
        for (int k = 0; k < FU; k++)
            for (int m = 0; m < MO; m++)
                if (set_prn_ready[k][m] && set_prn[k][m] == p) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: compare at negedge, advance the model at posedge, return 1 time unit later.
    task automatic tick();
        logic [IQ-1:0] cand, ev;
        logic [MO-1:0] epr;
        bit fire, acc, found, exp_inr;
        int g;
        @(negedge clk);
        cand  = m_valid ? (m_mask & iq_queue_ready) : '0;
        fire  = m_valid && (cand != '0) && !flush;
        g     = 0;
        found = 0;
        for (int o = 0; o < IQ; o++) begin
            if (!found && cand[(m_rr + o) % IQ]) begin
                found = 1;
                g = (m_rr + o) % IQ;
            end
        end
        ev      = fire ? (IQ'(1) << g) : '0;
        exp_inr = !flush && (!m_valid || fire || m_mask == '0);
        for (int i = 0; i < MO; i++) epr[i] = m_pr[i] | wake(m_prn[i]);
        check_eq("in_ready", 64'(in_ready), 64'(exp_inr));
        check_eq("iq_inst_valid", 64'(iq_inst_valid), 64'(ev));
        check_eq("route_err", 64'(route_err), 64'(m_valid && m_mask == '0));
        if (m_valid) begin
            check_eq("iq_inst_id", 64'(iq_inst_id), 64'(m_id));
            check_eq("iq_raw_instr", 64'(iq_raw_instr), 64'(m_raw));
            check_eq("iq_instr_pc", iq_instr_pc, m_pc);
            check_eq("iq_prn_input_valid", 64'(iq_prn_input_valid), 64'(m_pv));
            check_eq("iq_prn_input_ready", 64'(iq_prn_input_ready), 64'(epr));
            check_eq("iq_prn_input", 64'(iq_prn_input), 64'(m_prn));
            check_eq("iq_prn_output_valid", 64'(iq_prn_output_valid), 64'(m_ov));
            check_eq("iq_prn_output", 64'(iq_prn_output), 64'(m_op));
        end
`ifdef DISPATCH_STATS_EN
        check_eq("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        check_eq("dispatch_count", 64'(dispatch_count), 64'(m_disp));
`else
        check_eq("stall_cycles", 64'(stall_cycles), 64'd0);
        check_eq("dispatch_count", 64'(dispatch_count), 64'd0);
`endif
        obs_iv = iq_inst_valid; obs_inr = in_ready; obs_route = route_err;
        obs_pr = iq_prn_input_ready; obs_stall = stall_cycles;
        acc = in_valid && exp_inr;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_rr = 0; m_stall = 0; m_disp = 0;
        end else if (flush) begin
            m_valid = 0;
        end else begin
            if (fire) begin
                m_rr = (g + 1) % IQ;
                m_disp++;
            end
            if (m_valid && !fire && m_mask != '0) m_stall++;
            if (acc) begin
                m_valid = 1; m_id = in_inst_id; m_raw = in_raw_instr; m_pc = in_pc;
                m_mask = in_iq_mask; m_pv = in_prn_input_valid; m_prn = in_prn_input;
                m_ov = in_prn_output_valid; m_op = in_prn_output;
                for (int i = 0; i < MO; i++) m_pr[i] = in_prn_input_ready[i] | wake(in_prn_input[i]);
            end else if (m_valid && !fire && m_mask != '0) begin
                for (int i = 0; i < MO; i++) m_pr[i] = m_pr[i] | wake(m_prn[i]);
            end else begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic set_instr(input logic [IDB-1:0] id, input logic [IQ-1:0] mask);
        in_valid            = 1'b1;
        in_inst_id          = id;
        in_raw_instr        = $urandom;
        in_pc               = {$urandom, $urandom};
        in_iq_mask          = mask;
        in_prn_input_valid  = MO'($urandom);
        in_prn_input_ready  = MO'($urandom);
        in_prn_output_valid = MO'($urandom);
        for (int i = 0; i < MO; i++) begin
            in_prn_input[i]  = PB'($urandom_range(0, 15));
            in_prn_output[i] = PB'($urandom_range(0, 63));
        end
    endtask

    task automatic clear_wake();
        set_prn_ready = '0;
        set_prn       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        set_instr('0, '0); in_valid = 1'b0;
        clear_wake();
        iq_queue_ready = '1;
        @(posedge clk); #1;
        tick();
        rst = 1'b0;

        // Reset state
        tick();
        check_eq("rst_in_ready", 64'(obs_inr), 64'd1);
        check_eq("rst_iv", 64'(obs_iv), 64'd0);
        check_eq("rst_route", 64'(obs_route), 64'd0);
        check_eq("rst_inst_id", 64'(iq_inst_id), 64'd0);
        check_eq("rst_pc", iq_instr_pc, 64'd0);

        // Two instructions, mask 0011, round-robin 0 then 1, pointer lands on 2
        set_instr(6'd1, 4'b0011); tick();
        set_instr(6'd2, 4'b0011); tick();
        check_eq("t1_first_q0", 64'(obs_iv), 64'b0001);
        check_eq("t1_inr_a", 64'(obs_inr), 64'd1);
        set_instr(6'd3, 4'b1111); tick();
        check_eq("t1_second_q1", 64'(obs_iv), 64'b0010);
        check_eq("t1_inr_b", 64'(obs_inr), 64'd1);
        in_valid = 1'b0; tick();
        check_eq("t1_rr_at_2", 64'(obs_iv), 64'b0100);

        // Queue 2 busy for three cycles
        do_reset();
        iq_queue_ready = 4'b1011;
        set_instr(6'd4, 4'b0100); tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("t2_held_inr", 64'(obs_inr), 64'd0);
            check_eq("t2_held_iv", 64'(obs_iv), 64'd0);
        end
        iq_queue_ready = 4'b1111; tick();
        check_eq("t2_fire_q2", 64'(obs_iv), 64'b0100);
`ifdef DISPATCH_STATS_EN
        check_eq("t2_stall3", 64'(obs_stall), 64'd3);
`endif

        // Wakeup of prn 9 from another FU slot while stalled
        iq_queue_ready = 4'b0000;
        set_instr(6'd5, 4'b0001);
        in_prn_input[0] = 6'd3; in_prn_input[1] = 6'd9; in_prn_input[2] = 6'd11;
        in_prn_input_valid = 3'b111; in_prn_input_ready = 3'b000;
        tick();
        in_valid = 1'b0;
        set_prn_ready[2][0] = 1'b1; set_prn[2][0] = 6'd9; tick();
        clear_wake(); tick();
        iq_queue_ready = 4'b1111; tick();
        check_eq("t3_fire", 64'(obs_iv), 64'b0001);
        check_eq("t3_prn9_ready", 64'(obs_pr), 64'b010);

        // Wakeup of prn 5 on the insert cycle itself
        set_instr(6'd6, 4'b0001);
        in_prn_input[0] = 6'd5; in_prn_input[1] = 6'd12; in_prn_input[2] = 6'd13;
        in_prn_input_ready = 3'b000;
        tick();
        in_valid = 1'b0;
        set_prn_ready[1][2] = 1'b1; set_prn[1][2] = 6'd5; tick();
        clear_wake();
        check_eq("t4_fire", 64'(obs_iv), 64'b0001);
        check_eq("t4_prn5_ready", 64'(obs_pr), 64'b001);

        // Empty mask: route error, next instruction accepted the same cycle
        set_instr(6'd7, 4'b0000); tick();
        set_instr(6'd8, 4'b0010); tick();
        check_eq("t5_route_err", 64'(obs_route), 64'd1);
        check_eq("t5_no_iv", 64'(obs_iv), 64'd0);
        check_eq("t5_inr", 64'(obs_inr), 64'd1);
        in_valid = 1'b0; tick();
        check_eq("t5_next_q1", 64'(obs_iv), 64'b0010);
        check_eq("t5_route_clear", 64'(obs_route), 64'd0);

        // Flush while holding with an incoming instruction; pointer survives
        iq_queue_ready = 4'b0000;
        set_instr(6'd9, 4'b1111); tick();
        iq_queue_ready = 4'b1111;
        flush = 1'b1; set_instr(6'd10, 4'b1111); tick();
        check_eq("t6_flush_iv", 64'(obs_iv), 64'd0);
        check_eq("t6_flush_inr", 64'(obs_inr), 64'd0);
        flush = 1'b0; in_valid = 1'b0; tick();
        check_eq("t6_empty_after", 64'(obs_iv), 64'd0);
        set_instr(6'd11, 4'b1111); tick();
        in_valid = 1'b0; tick();
        check_eq("t6_rr_kept", 64'(obs_iv), 64'b0100);

        // Randomized traffic, including occasional flush and mid-run reset
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 19) == 0);
            set_instr(IDB'($urandom), ($urandom_range(0, 15) == 0) ? 4'b0000 : IQ'($urandom_range(1, 15)));
            in_valid       = ($urandom_range(0, 3) != 0);
            iq_queue_ready = IQ'($urandom);
            for (int k = 0; k < FU; k++)
                for (int m = 0; m < MO; m++) begin
                    set_prn_ready[k][m] = ($urandom_range(0, 7) == 0);
                    set_prn[k][m]       = PB'($urandom_range(0, 15));
                end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
